// File: rtl/network_output_queue_sched.sv
// Multi-class output queue scheduler: strict-priority or round-robin pick over per-class descriptor FIFOs, one descriptor in flight.
// Latency: grant decision in IDLE -> read strobe next cycle -> descriptor write strobe two cycles after the read strobe; min 4 cycles between writes.
// Backpressure: no FIFO read is issued while i_descriptor_ready is low; after a write the scheduler holds until ready returns.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_sched_mode          0 = strict priority (queue 0 highest), 1 = round robin
//   iv_queue_enable       per-queue eligibility mask
//   iv_fifo_empty         per-FIFO empty flags
//   ov_fifo_rd            per-FIFO read strobe (one-hot or zero)
//   iv_fifo_rdata         concatenated FIFO read data, queue k at [k*DESC_WIDTH +: DESC_WIDTH], valid one cycle after rd
//   ov_descriptor         descriptor to the consumer
//   ov_queue_id           source queue of ov_descriptor
//   o_descriptor_wr       one-cycle write strobe
//   i_descriptor_ready    consumer ready level
//   ov_desc_cnt           wrapping count of emitted descriptors
module network_output_queue_sched #(
    parameter int DESC_WIDTH = 57,
    parameter int QUEUE_NUM  = 8,
    parameter int QID_WIDTH  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_sched_mode,
    input  logic [QUEUE_NUM-1:0]            iv_queue_enable,
    input  logic [QUEUE_NUM-1:0]            iv_fifo_empty,
    output logic [QUEUE_NUM-1:0]            ov_fifo_rd,
    input  logic [QUEUE_NUM*DESC_WIDTH-1:0] iv_fifo_rdata,
    output logic [DESC_WIDTH-1:0]           ov_descriptor,
    output logic [QID_WIDTH-1:0]            ov_queue_id,
    output logic                            o_descriptor_wr,
    input  logic                            i_descriptor_ready,
    output logic [CNT_WIDTH-1:0]            ov_desc_cnt
);

    typedef enum logic [1:0] {
        IDLE_S   = 2'd0,
        READ_S   = 2'd1,
        OUTPUT_S = 2'd2,
        WAIT_S   = 2'd3
    } state_t;

    state_t                 state;
    logic [QID_WIDTH-1:0]   grant_id;
    logic                   grant_rr;   // mode latched at grant time, so a mid-transfer mode flip cannot move the pointer
    logic [QID_WIDTH-1:0]   rr_ptr;     // last queue served in round-robin mode

    logic [QUEUE_NUM-1:0]   eligible;
    logic                   any_eligible;
    logic [QID_WIDTH-1:0]   sp_id;
    logic [QID_WIDTH-1:0]   rr_id;
    logic [QID_WIDTH-1:0]   next_id;
    logic [QUEUE_NUM-1:0]   next_onehot;
    logic [DESC_WIDTH-1:0]  sel_data;
    int                     rr_dist;
    int                     rr_best;

    assign eligible     = ~iv_fifo_empty & iv_queue_enable;
    assign any_eligible = |eligible;
    assign next_id      = i_sched_mode ? rr_id : sp_id;

    // Strict priority: scanning from the top down leaves the lowest eligible index.
    always_comb begin
        sp_id = '0;
        for (int i = QUEUE_NUM - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sp_id = QID_WIDTH'(i);
            end
        end
    end

    // Round robin: distance of queue i from the slot after rr_ptr, modulo QUEUE_NUM;
    // the eligible queue with the smallest distance wins.
    always_comb begin
        rr_id   = '0;
        rr_best = QUEUE_NUM;
        rr_dist = 0;
        for (int i = 0; i < QUEUE_NUM; i++) begin
            rr_dist = (i + QUEUE_NUM - 1 - int'(rr_ptr)) % QUEUE_NUM;
            if (eligible[i] && (rr_dist < rr_best)) begin
                rr_best = rr_dist;
                rr_id   = QID_WIDTH'(i);
            end
        end
    end

    // Constant-index decode and data mux keep all selects static.
    always_comb begin
        next_onehot = '0;
        sel_data    = '0;
        for (int i = 0; i < QUEUE_NUM; i++) begin
            next_onehot[i] = (next_id == QID_WIDTH'(i));
            if (grant_id == QID_WIDTH'(i)) begin
                sel_data = iv_fifo_rdata[i*DESC_WIDTH +: DESC_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= IDLE_S;
            ov_fifo_rd      <= '0;
            ov_descriptor   <= '0;
            ov_queue_id     <= '0;
            o_descriptor_wr <= 1'b0;
            ov_desc_cnt     <= '0;
            grant_id        <= '0;
            grant_rr        <= 1'b0;
            rr_ptr          <= QID_WIDTH'(QUEUE_NUM - 1);
        end else begin
            case (state)
                IDLE_S: begin
                    ov_descriptor   <= '0;
                    o_descriptor_wr <= 1'b0;
                    if (i_descriptor_ready && any_eligible) begin
                        ov_fifo_rd <= next_onehot;
                        grant_id   <= next_id;
                        grant_rr   <= i_sched_mode;
                        state      <= READ_S;
                    end else begin
                        ov_fifo_rd <= '0;
                    end
                end
                READ_S: begin
                    // FIFO samples the strobe at this edge; data arrives in OUTPUT_S.
                    ov_fifo_rd <= '0;
                    state      <= OUTPUT_S;
                end
                OUTPUT_S: begin
                    ov_descriptor   <= sel_data;
                    ov_queue_id     <= grant_id;
                    o_descriptor_wr <= 1'b1;
                    ov_desc_cnt     <= ov_desc_cnt + 1'b1;
                    if (grant_rr) begin
                        rr_ptr <= grant_id;
                    end
                    state <= WAIT_S;
                end
                WAIT_S: begin
                    ov_descriptor   <= '0;
                    o_descriptor_wr <= 1'b0;
                    ov_fifo_rd      <= '0;
                    if (i_descriptor_ready) begin
                        state <= IDLE_S;
                    end
                end
                default: begin
                    ov_fifo_rd      <= '0;
                    ov_descriptor   <= '0;
                    o_descriptor_wr <= 1'b0;
                    state           <= IDLE_S;
                end
            endcase
        end
    end

endmodule
